sevenseg_scan_driver: RTL and testbench

SEVENSEG_SCAN_DRIVER -- requirements
Module: sevenseg_scan_driver

---
 rtl/sevenseg_pkg.sv | 18 +
 rtl/sevenseg_scan_timer.sv | 56 +++++
 rtl/sevenseg_scan_driver.sv | 146 ++++++++++++++
 tb/tb_sevenseg_scan_driver.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Font table and sizing helpers for the multiplexed seven-segment display driver.
package sevenseg_pkg;

    // Segment patterns with lit = 1, bit0 = a ... bit6 = g, indexed by hex nibble.
    localparam logic [6:0] SEG_FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_font(input logic [3:0] nib);
        return SEG_FONT[nib];
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sevenseg_scan_timer.sv
// Slot counter and digit index for the display scan; frame_done marks the last slot's wrap.
module sevenseg_scan_timer
    import sevenseg_pkg::*;
#(
    parameter int  NUM_DIGITS = 4,
    parameter int  SLOT_CYC   = 50000,
    localparam int CNT_W      = $clog2(SLOT_CYC),
    localparam int DIG_W      = idx_width(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] slot_cnt_o,
    output logic [DIG_W-1:0] digit_idx_o,
    output logic             frame_done_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYC - 1);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIG_W-1:0] dig_q, dig_d;
    logic             wrap;

    assign wrap = en_i && (cnt_q == CNT_LAST);

    // Disabling parks the scan at digit 0, counter 0, so re-enabling starts a clean frame.
    always_comb begin
        cnt_d = cnt_q;
        dig_d = dig_q;
        if (!en_i) begin
            cnt_d = '0;
            dig_d = '0;
        end else if (wrap) begin
            cnt_d = '0;
            dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            dig_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            dig_q <= dig_d;
        end
    end

    assign slot_cnt_o   = cnt_q;
    assign digit_idx_o  = dig_q;
    assign frame_done_o = wrap && (dig_q == DIG_LAST);

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed seven-segment driver: pending/display double buffer, leading-zero
// suppression, blanking at each slot start and registered segment/digit outputs.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SLOT_CYC       = 50000,
    parameter int BLANK_CYC      = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank,
    input  logic                    load,
    output logic [6:0]              sevenseg,
    output logic                    decout,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(SLOT_CYC);
    localparam int DIG_W = idx_width(NUM_DIGITS);

    // XOR masks turning lit = 1 patterns into pin polarity; also the dark values.
    localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

    logic [CNT_W-1:0]        slot_cnt;
    logic [DIG_W-1:0]        digit_idx;
    logic                    in_blank;

    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic                    pend_lz_q, pend_lz_d, disp_lz_q, disp_lz_d;

    logic [NUM_DIGITS-1:0]   lz_hide;
    logic                    upper_zero;
    logic [NUM_DIGITS-1:0]   an_lit;
    logic [6:0]              seg_lit;
    logic                    dec_lit;

    logic [6:0]              seg_q, seg_d;
    logic                    dec_q, dec_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    sevenseg_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SLOT_CYC   (SLOT_CYC)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en),
        .slot_cnt_o   (slot_cnt),
        .digit_idx_o  (digit_idx),
        .frame_done_o (frame_done)
    );

    if (BLANK_CYC == 0) begin : g_no_blank
        assign in_blank = 1'b0;
    end else begin : g_blank
        assign in_blank = (slot_cnt < CNT_W'(BLANK_CYC));
    end

    // Display registers only change at frame end, so a frame never mixes old and new data.
    always_comb begin
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pend_lz_d  = pend_lz_q;
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        disp_lz_d  = disp_lz_q;
        if (load) begin
            pend_val_d = value;
            pend_dp_d  = dp_in;
            pend_lz_d  = lz_blank;
        end
        if (frame_done) begin
            disp_val_d = pend_val_q;
            disp_dp_d  = pend_dp_q;
            disp_lz_d  = pend_lz_q;
        end
    end

    // Digit i is hidden when it and every more significant nibble are zero; digit 0 never is.
    always_comb begin
        upper_zero = 1'b1;
        lz_hide    = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (disp_val_q[4*i +: 4] == 4'h0);
            lz_hide[i] = disp_lz_q && upper_zero;
        end
    end

    always_comb begin
        an_lit  = '0;
        seg_lit = '0;
        dec_lit = 1'b0;
        if (en && !in_blank) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (digit_idx == DIG_W'(i)) begin
                    an_lit[i] = 1'b1;
                    dec_lit   = disp_dp_q[i];
                    seg_lit   = lz_hide[i] ? 7'h00 : seg_font(disp_val_q[4*i +: 4]);
                end
            end
        end
    end

    assign seg_d = seg_lit ^ SEG_OFF;
    assign dec_d = dec_lit ^ DP_OFF;
    assign an_d  = an_lit ^ AN_OFF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            pend_lz_q  <= 1'b0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            disp_lz_q  <= 1'b0;
            seg_q      <= SEG_OFF;
            dec_q      <= DP_OFF;
            an_q       <= AN_OFF;
        end else begin
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            pend_lz_q  <= pend_lz_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            disp_lz_q  <= disp_lz_d;
            seg_q      <= seg_d;
            dec_q      <= dec_d;
            an_q       <= an_d;
        end
    end

    assign sevenseg = seg_q;
    assign decout   = dec_q;
    assign an       = an_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Scoreboard bench for sevenseg_scan_driver with 4 digits, 4-cycle slots, 1 blank cycle.
module tb_sevenseg_scan_driver;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    typedef struct packed {
        logic [7:0]  p;
        logic [15:0] v;
        logic [3:0]  dp;
        logic        lz;
    } ld_t;

    localparam exp_t       DARK   = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};
    localparam ld_t        NO_LD  = '{p: 8'hFF, v: 16'h0, dp: 4'h0, lz: 1'b0};
    localparam logic [7:0] OFF_LD = 8'd99;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        lz_blank;
    logic        load;
    logic [6:0]  sevenseg;
    logic        decout;
    logic [3:0]  an;
    logic        frame_done;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    sevenseg_scan_driver #(
        .NUM_DIGITS     (4),
        .SLOT_CYC       (4),
        .BLANK_CYC      (1),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .value      (value),
        .dp_in      (dp_in),
        .lz_blank   (lz_blank),
        .load       (load),
        .sevenseg   (sevenseg),
        .decout     (decout),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] font_al(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Phase p of a frame: p%4 == 0 is the blank cycle, otherwise digit p/4 is lit.
    function automatic exp_t exp_at(input int p, input logic [15:0] v, input logic [3:0] dp,
                                    input logic lz);
        exp_t e;
        int   d;
        logic sup;
        d    = p / 4;
        e    = DARK;
        e.fd = (p == 14);
        if (p % 4 != 0) begin
            e.an[d] = 1'b0;
            sup     = lz && (d >= 1) && ((v >> (4 * d)) == 16'h0);
            e.seg   = sup ? 7'h7F : font_al(v[4*d +: 4]);
            e.dp    = ~dp[d];
        end
        return e;
    endfunction

    function automatic ld_t mk_ld(input int p, input logic [15:0] v, input logic [3:0] dp,
                                  input logic lz);
        ld_t l;
        l.p  = 8'(p);
        l.v  = v;
        l.dp = dp;
        l.lz = lz;
        return l;
    endfunction

    task automatic tick(input exp_t e);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        load = 1'b0;
    endtask

    task automatic drive_load(input ld_t l);
        load     = 1'b1;
        value    = l.v;
        dp_in    = l.dp;
        lz_blank = l.lz;
    endtask

    task automatic check_dark(input string tag);
        n_chk++;
        if ({an, sevenseg, decout, frame_done} !== {DARK.an, DARK.seg, DARK.dp, DARK.fd}) begin
            n_fail++;
            $display("FAIL %s: got an=%h seg=%h dp=%b fd=%b, want an=f seg=7f dp=1 fd=0",
                     tag, an, sevenseg, decout, frame_done);
        end
    endtask

    // One frame of expected output; a and b are loads issued at given phases, off_p drops en.
    task automatic run_frame(input logic [15:0] ev, input logic [3:0] edp, input logic elz,
                             input ld_t a, input ld_t b, input int off_p, input int n_ph);
        for (int p = 0; p < n_ph; p++) begin
            if (p == off_p) begin
                en = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    if (k == 1 && b.p == OFF_LD) drive_load(b);
                    tick(DARK);
                end
                en = 1'b1;
                break;
            end
            if (int'(a.p) == p) drive_load(a);
            if (int'(b.p) == p) drive_load(b);
            tick(exp_at(p, ev, edp, elz));
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            n_chk++;
            if ({an, sevenseg, decout} !== {mon_e.an, mon_e.seg, mon_e.dp}) begin
                n_fail++;
                $display("FAIL display @%0t: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                         $time, an, sevenseg, decout, mon_e.an, mon_e.seg, mon_e.dp);
            end
            n_chk++;
            if (frame_done !== mon_e.fd) begin
                n_fail++;
                $display("FAIL frame_done @%0t: got %b, want %b", $time, frame_done, mon_e.fd);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b1;
        en       = 1'b0;
        value    = 16'h0;
        dp_in    = 4'h0;
        lz_blank = 1'b0;
        load     = 1'b0;
        #1 rst_n = 1'b0;
        #2 check_dark("reset_async");
        tick(DARK);
        tick(DARK);
        rst_n = 1'b1;
        tick(DARK);
        tick(DARK);
        en = 1'b1;

        run_frame(16'h0000, 4'h0, 1'b0, mk_ld(5, 16'h1234, 4'h0, 1'b0), NO_LD, -1, 16);
        run_frame(16'h1234, 4'h0, 1'b0, mk_ld(3, 16'h00A0, 4'b0100, 1'b1), NO_LD, -1, 16);
        run_frame(16'h00A0, 4'b0100, 1'b1, mk_ld(6, 16'hFFFF, 4'h0, 1'b0),
                  mk_ld(15, 16'h8888, 4'h0, 1'b0), -1, 16);
        run_frame(16'hFFFF, 4'h0, 1'b0, mk_ld(1, 16'h0000, 4'h0, 1'b0), NO_LD, -1, 16);
        run_frame(16'h0000, 4'h0, 1'b0, mk_ld(9, 16'h0000, 4'b0001, 1'b1), NO_LD, -1, 16);
        run_frame(16'h0000, 4'b0001, 1'b1, mk_ld(0, 16'h0204, 4'b0100, 1'b1), NO_LD, -1, 16);
        run_frame(16'h0204, 4'b0100, 1'b1, NO_LD, NO_LD, -1, 16);
        run_frame(16'h0204, 4'b0100, 1'b1, NO_LD, mk_ld(OFF_LD, 16'h5678, 4'h0, 1'b0), 10, 16);
        run_frame(16'h0204, 4'b0100, 1'b1, NO_LD, NO_LD, -1, 16);
        run_frame(16'h5678, 4'h0, 1'b0, mk_ld(3, 16'h9ABC, 4'hF, 1'b1), NO_LD, -1, 6);

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_dark("reset_mid_slot");
        tick(DARK);
        tick(DARK);
        rst_n = 1'b1;
        run_frame(16'h0000, 4'h0, 1'b0, NO_LD, NO_LD, -1, 16);
        run_frame(16'h0000, 4'h0, 1'b0, NO_LD, NO_LD, -1, 16);

        @(negedge clk);
        #1;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
